// File: rtl/osc_clkdiv.sv
// osc_clkdiv: start-up sequencer and glitch-free /2../16 clock divider
// fed from the oscillator CLKM output.
module osc_clkdiv #(
  parameter int unsigned STARTUP_CYC = 16,
  parameter logic [1:0]  DIV_RESET   = 2'b00
) (
  input  logic       CLKM,
  input  logic       RSTN,
  input  logic [1:0] DIV_SEL,
  input  logic       DIV_REQ,
  input  logic       ENA,
  output logic       CLKOUT,
  output logic       READY,
  output logic       DIV_ACK
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t     state, state_n;
  logic       phase, phase_n;
  logic [2:0] cnt, cnt_n;
  logic [1:0] cur_sel, cur_n;
  logic [1:0] pend_sel, pend_n;
  logic       ena_q, ena_n;
  logic [7:0] su_cnt, su_n;
  logic       rdy_n;
  logic       ack_n;
  logic       wack, wack_n;
  logic       clk_n;

  logic [2:0] h_m1;
  logic       tgl;
  logic       fall;
  logic       su_done;

  always_comb begin
    h_m1 = 3'd0;
    unique case (cur_sel)
      2'd0: h_m1 = 3'd0;
      2'd1: h_m1 = 3'd1;
      2'd2: h_m1 = 3'd3;
      2'd3: h_m1 = 3'd7;
      default: h_m1 = 3'd0;
    endcase
  end

  assign tgl     = (cnt == h_m1);
  assign fall    = tgl & phase;
  assign su_done = (su_cnt == 8'(STARTUP_CYC - 1));

  always_ff @(posedge CLKM or negedge RSTN) begin
    if (!RSTN) state <= S_WAIT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_WAIT: if (su_done) state_n = S_RUN;
      S_RUN:  if (DIV_REQ) state_n = S_PEND;
      S_PEND: if (fall)    state_n = S_RUN;
      default: state_n = S_WAIT;
    endcase
  end

  always_comb begin
    phase_n = phase;
    cnt_n   = cnt;
    cur_n   = cur_sel;
    pend_n  = pend_sel;
    ena_n   = ena_q;
    su_n    = su_cnt;
    rdy_n   = READY;
    ack_n   = wack;
    wack_n  = 1'b0;
    unique case (state)
      S_WAIT: begin
        su_n    = su_cnt + 8'd1;
        phase_n = 1'b0;
        cnt_n   = 3'd0;
        if (DIV_REQ) begin
          cur_n  = DIV_SEL;
          wack_n = 1'b1;
        end
        if (su_done) begin
          rdy_n = 1'b1;
          ena_n = ENA;
        end
      end
      S_RUN, S_PEND: begin
        if (tgl) begin
          phase_n = ~phase;
          cnt_n   = 3'd0;
        end else begin
          cnt_n = cnt + 3'd1;
        end
        if (fall) ena_n = ENA;
        if (state == S_RUN) begin
          if (DIV_REQ) pend_n = DIV_SEL;
        end else if (fall) begin
          cur_n = pend_sel;
          ack_n = 1'b1;
        end else if (DIV_REQ) begin
          pend_n = DIV_SEL;
        end
      end
      default: ;
    endcase
    // falling edge is the only point where ratio or enable may change
    clk_n = phase_n & ena_n;
  end

  always_ff @(posedge CLKM or negedge RSTN) begin
    if (!RSTN) begin
      phase    <= 1'b0;
      cnt      <= 3'd0;
      cur_sel  <= DIV_RESET;
      pend_sel <= DIV_RESET;
      ena_q    <= 1'b0;
      su_cnt   <= 8'd0;
      READY    <= 1'b0;
      DIV_ACK  <= 1'b0;
      wack     <= 1'b0;
      CLKOUT   <= 1'b0;
    end else begin
      phase    <= phase_n;
      cnt      <= cnt_n;
      cur_sel  <= cur_n;
      pend_sel <= pend_n;
      ena_q    <= ena_n;
      su_cnt   <= su_n;
      READY    <= rdy_n;
      DIV_ACK  <= ack_n;
      wack     <= wack_n;
      CLKOUT   <= clk_n;
    end
  end

endmodule

// File: tb/tb_osc_clkdiv.sv
// tb_osc_clkdiv: directed checks of start-up, ratio handshake,
// enable gating and reset for osc_clkdiv.
module tb_osc_clkdiv;

  logic       CLKM = 1'b0;
  logic       RSTN = 1'b0;
  logic [1:0] DIV_SEL = 2'b00;
  logic       DIV_REQ = 1'b0;
  logic       ENA = 1'b1;
  logic       CLKOUT;
  logic       READY;
  logic       DIV_ACK;

  int total = 0;
  int bad = 0;
  int ack_cnt = 0;
  int n;
  int hi;

  osc_clkdiv #(
    .STARTUP_CYC(16),
    .DIV_RESET(2'b00)
  ) dut (
    .CLKM(CLKM),
    .RSTN(RSTN),
    .DIV_SEL(DIV_SEL),
    .DIV_REQ(DIV_REQ),
    .ENA(ENA),
    .CLKOUT(CLKOUT),
    .READY(READY),
    .DIV_ACK(DIV_ACK)
  );

  always #5 CLKM = ~CLKM;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLKM);
    #1;
    if (DIV_ACK === 1'b1) ack_cnt++;
  endtask

  task automatic until_out(input logic v, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (CLKOUT !== v && k < 100);
  endtask

  task automatic wait_ack(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (DIV_ACK !== 1'b1 && k < 100);
  endtask

  initial begin
    // reset state
    repeat (3) step();
    chk("rst_clk", 32'(CLKOUT), 0);
    chk("rst_rdy", 32'(READY), 0);
    chk("rst_ack", 32'(DIV_ACK), 0);
    RSTN = 1'b1;

    // start-up and /2
    repeat (15) step();
    chk("su15_rdy", 32'(READY), 0);
    chk("su15_clk", 32'(CLKOUT), 0);
    step();
    chk("su16_rdy", 32'(READY), 1);
    chk("su16_clk", 32'(CLKOUT), 0);
    step();
    chk("d2_e17", 32'(CLKOUT), 1);
    step();
    chk("d2_e18", 32'(CLKOUT), 0);
    step();
    chk("d2_e19", 32'(CLKOUT), 1);

    // /2 -> /16 requested while high
    DIV_SEL = 2'd3;
    DIV_REQ = 1'b1;
    step();
    DIV_REQ = 1'b0;
    chk("d16_e20_clk", 32'(CLKOUT), 0);
    chk("d16_e20_ack", 32'(DIV_ACK), 0);
    step();
    chk("d16_e21_clk", 32'(CLKOUT), 1);
    ack_cnt = 0;
    step();
    chk("d16_ack", 32'(DIV_ACK), 1);
    chk("d16_ack_clk", 32'(CLKOUT), 0);
    until_out(1'b1, n);
    chk("d16_first_rise", n, 8);
    chk("d16_ack_once", ack_cnt, 1);
    until_out(1'b0, n);
    chk("d16_high", n, 8);
    until_out(1'b1, n);
    chk("d16_low", n, 8);

    // go to /8, then latest request wins
    DIV_SEL = 2'd2;
    DIV_REQ = 1'b1;
    step();
    DIV_REQ = 1'b0;
    wait_ack(n);
    chk("d8_lat", n, 7);
    ack_cnt = 0;
    DIV_SEL = 2'd1;
    DIV_REQ = 1'b1;
    step();
    DIV_REQ = 1'b0;
    step();
    DIV_SEL = 2'd3;
    DIV_REQ = 1'b1;
    step();
    DIV_REQ = 1'b0;
    wait_ack(n);
    chk("lw_lat", n, 5);
    until_out(1'b1, n);
    chk("lw_rise", n, 8);
    until_out(1'b0, n);
    chk("lw_high", n, 8);
    chk("lw_one_ack", ack_cnt, 1);

    // /4 with enable gating
    DIV_SEL = 2'd1;
    DIV_REQ = 1'b1;
    step();
    DIV_REQ = 1'b0;
    wait_ack(n);
    chk("d4_lat", n, 15);
    until_out(1'b1, n);
    chk("d4_rise", n, 2);
    ENA = 1'b0;
    step();
    chk("en_hold_hi", 32'(CLKOUT), 1);
    step();
    chk("en_fall", 32'(CLKOUT), 0);
    hi = 0;
    repeat (8) begin
      step();
      if (CLKOUT === 1'b1) hi++;
    end
    chk("en_quiet", hi, 0);
    ENA = 1'b1;
    until_out(1'b1, n);
    chk("en_rerise", n, 6);
    until_out(1'b0, n);
    chk("en_high", n, 2);

    // reset while pending at /8
    DIV_SEL = 2'd2;
    DIV_REQ = 1'b1;
    step();
    DIV_REQ = 1'b0;
    wait_ack(n);
    chk("p8_lat", n, 3);
    DIV_SEL = 2'd1;
    DIV_REQ = 1'b1;
    step();
    DIV_REQ = 1'b0;
    repeat (4) step();
    chk("pend_hi", 32'(CLKOUT), 1);
    #2;
    RSTN = 1'b0;
    #1;
    chk("arst_clk", 32'(CLKOUT), 0);
    chk("arst_rdy", 32'(READY), 0);
    chk("arst_ack", 32'(DIV_ACK), 0);
    ack_cnt = 0;
    repeat (2) step();
    RSTN = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (READY !== 1'b1 && n < 100);
    chk("arst_su", n, 16);
    chk("arst_noack", ack_cnt, 0);
    until_out(1'b1, n);
    chk("arst_d2_rise", n, 1);
    until_out(1'b0, n);
    chk("arst_d2_high", n, 1);

    // request during start-up
    RSTN = 1'b0;
    repeat (2) step();
    RSTN = 1'b1;
    repeat (4) step();
    DIV_SEL = 2'd2;
    DIV_REQ = 1'b1;
    step();
    DIV_REQ = 1'b0;
    chk("w_ack5", 32'(DIV_ACK), 0);
    step();
    chk("w_ack6", 32'(DIV_ACK), 1);
    repeat (9) step();
    chk("w_rdy15", 32'(READY), 0);
    step();
    chk("w_rdy16", 32'(READY), 1);
    until_out(1'b1, n);
    chk("w_rise", n, 4);
    until_out(1'b0, n);
    chk("w_high", n, 4);
    until_out(1'b1, n);
    chk("w_low", n, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/osc_clkdiv.md
# osc_clkdiv

Programmable clock divider and start-up sequencer that sits directly downstream of the oscillator model and consumes its CLKM output. It holds its output quiet for a fixed settling interval after reset, then produces a 50%-duty divided clock (/2, /4, /8, /16). Ratio changes use a request/acknowledge handshake and are applied only at a falling output edge, so the output never glitches or produces a runt pulse. The output enable is re-timed to the divided clock's falling edge, mirroring the enable style of the oscillator stage.

## Interface
- STARTUP_CYC, 16: CLKM cycles after reset release before READY rises; range 1..255.
- DIV_RESET, 2'b00: ratio code loaded at reset.
- CLKM  input  1  source clock from oscillator; all logic on posedge.
- RSTN  input  1  reset, asynchronous, active-low.
- DIV_SEL  input  2  ratio code: 00 = /2, 01 = /4, 10 = /8, 11 = /16.
- DIV_REQ  input  1  level-sampled each cycle; 1 = load DIV_SEL.
- ENA  input  1  output enable.
- CLKOUT  output  1  divided clock, registered.
- READY  output  1  start-up interval complete.
- DIV_ACK  output  1  one-cycle pulse when a requested ratio takes effect.

## Operation
- Half-period H = 1 << cur_sel, giving 1, 2, 4 or 8 cycles. Output period = 2H.
- Internal: phase bit, 3-bit half-period counter cnt, cur_sel, pend_sel, ena_q, 8-bit start-up counter.
- Toggle event: cnt == H-1, which sets phase <= ~phase and cnt <= 0. Otherwise cnt++.
- Falling event: toggle event while phase == 1.
- CLKOUT is registered as CLKOUT <= phase_next & ena_q_next. It is never a combinational AND.
- States:
  - WAIT
    - Start-up counter increments each cycle. Divider is frozen: phase = 0, cnt = 0.
    - When the count reaches STARTUP_CYC: READY <= 1, ena_q <= ENA, go to RUN.
    - DIV_REQ in WAIT: cur_sel <= DIV_SEL immediately, with a DIV_ACK pulse the next cycle.
  - RUN
    - Divider runs.
    - At each falling event: ena_q <= ENA.
    - DIV_REQ: pend_sel <= DIV_SEL, go to PEND.
  - PEND
    - Divider continues at the old ratio.
    - DIV_REQ again: pend_sel is overwritten (latest wins). Only one ACK is issued.
    - At the falling event:
      - cur_sel <= pend_sel, cnt <= 0, phase <= 0, ena_q <= ENA.
      - DIV_ACK <= 1 for exactly one cycle.
      - Return to RUN.
      - A DIV_REQ in that same cycle is ignored.
    - A request for the current ratio still goes through PEND and is acknowledged.
- ENA low:
  - A high phase already in progress completes its full H cycles.
  - From the next falling event onward, CLKOUT stays 0. Divider and handshake continue.
- ENA re-asserted: takes effect at the next falling event. The first CLKOUT rise comes H cycles later.
- Reset (RSTN = 0, asynchronous, any time):
  - CLKOUT = 0, READY = 0, DIV_ACK = 0.
  - phase = 0, cnt = 0, ena_q = 0, start-up counter = 0.
  - cur_sel = pend_sel = DIV_RESET, state = WAIT.
  - Any pending change is discarded, with no ACK.

## Timing
- READY rises on the STARTUP_CYC-th posedge after RSTN deasserts.
- First CLKOUT rise comes H posedges after READY rises, when ENA = 1.
- High and low phases are each exactly H CLKM cycles. There is no partial phase, including across a ratio change.
- DIV_ACK is asserted on the same posedge that applies the new ratio. CLKOUT is low on that edge.
- The new ratio's first rise comes H_new cycles after DIV_ACK.
- Worst-case request-to-ACK latency:
  - is 2H_old cycles.
  - is 1 cycle in WAIT.
- Outputs change only on posedge CLKM, except for the asynchronous reset clear.

## Test plan
- Start-up and /2 output: STARTUP_CYC = 16, DIV_RESET = 00, ENA = 1, release RSTN -> READY rises on posedge 16; CLKOUT rises at posedge 17 and then toggles every cycle (period 2).
- Ratio /2 -> /16 change: DIV_REQ with 11 pulsed while CLKOUT is high -> high phase completes; DIV_ACK is a single pulse with CLKOUT low; CLKOUT is then 8 cycles high, 8 cycles low.
- Latest request wins: while in /8, DIV_REQ 01, then DIV_REQ 11 two cycles later (both before the falling event) -> exactly one DIV_ACK; resulting period is 16.
- Enable gating: at /4, ENA is dropped during the first cycle of a high phase -> CLKOUT stays high 2 cycles, then remains 0. ENA is raised -> CLKOUT stays 0 until the next falling event, then rises 2 cycles later.
- Reset mid-operation: at /8 in PEND, assert RSTN -> CLKOUT, READY and DIV_ACK go 0 immediately with no ACK. After release, READY rises after 16 cycles at DIV_RESET ratio.
- Request during WAIT: DIV_REQ with 10 at cycle 5 after release -> DIV_ACK pulses at cycle 6; READY still at cycle 16; first CLKOUT period is 8.
